renaming_register_file: RTL and testbench

RENAMING_REGISTER_FILE -- requirements
Module: renaming_register_file

---
 rtl/ooo_pkg.sv | 21 ++
 rtl/rf_operand_lookup.sv | 63 ++++++
 rtl/renaming_register_file.sv | 138 +++++++++++++
 tb/tb_renaming_register_file.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: rename-table entry and default widths.
// Tag/data widths of the entry struct are the package defaults.
package ooo_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int XLEN_DEF     = 32;
  localparam int TAG_W_DEF    = 3;
  localparam int REG_IDX_W    = 5;

  typedef struct packed {
    logic                 busy;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  value;
  } rf_entry_t;

  // Producer tag presented on a data lane, zero-extended.
  function automatic logic [XLEN_DEF-1:0] tag_to_val(input logic [TAG_W_DEF-1:0] t);
    return {{(XLEN_DEF-TAG_W_DEF){1'b0}}, t};
  endfunction

endpackage

// File: rtl/rf_operand_lookup.sv
// Resolves one source operand of one dispatch lane: register 0, older-lane
// producer in the same bundle, committed value, or pending tag.
module rf_operand_lookup
  import ooo_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LANE  = 0
) (
  input  logic [REG_IDX_W-1:0]       src,
  input  rf_entry_t                  entry,
  input  logic [LANES-1:0]           disp_valid,
  input  logic [LANES-1:0]           disp_wr,
  input  logic [LANES*REG_IDX_W-1:0] disp_rd,
  input  logic [LANES*TAG_W_DEF-1:0] disp_tag,
  input  logic                       cm_valid,
  input  logic [TAG_W_DEF-1:0]       cm_tag,
  input  logic [XLEN_DEF-1:0]        cm_data,
  output logic                       rdy,
  output logic [XLEN_DEF-1:0]        val
);

  logic                 byp_hit_s;
  logic [TAG_W_DEF-1:0] byp_tag_s;

  // Youngest older lane writing src wins: ascending scan lets later lanes override.
  always_comb begin
    byp_hit_s = 1'b0;
    byp_tag_s = {TAG_W_DEF{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if ((i < LANE) && disp_valid[i] && disp_wr[i] &&
          (disp_rd[i*REG_IDX_W +: REG_IDX_W] == src)) begin
        byp_hit_s = 1'b1;
        byp_tag_s = disp_tag[i*TAG_W_DEF +: TAG_W_DEF];
      end else begin
        byp_hit_s = byp_hit_s;
        byp_tag_s = byp_tag_s;
      end
    end
  end

  // Priority: r0, in-bundle producer, settled value, same-cycle commit, pending tag.
  always_comb begin
    rdy = 1'b0;
    val = {XLEN_DEF{1'b0}};
    if (src == {REG_IDX_W{1'b0}}) begin
      rdy = 1'b1;
      val = {XLEN_DEF{1'b0}};
    end else if (byp_hit_s) begin
      rdy = 1'b0;
      val = tag_to_val(byp_tag_s);
    end else if (!entry.busy) begin
      rdy = 1'b1;
      val = entry.value;
    end else if (cm_valid && (cm_tag == entry.tag)) begin
      rdy = 1'b1;
      val = cm_data;
    end else begin
      rdy = 1'b0;
      val = tag_to_val(entry.tag);
    end
  end

endmodule

// File: rtl/renaming_register_file.sv
// Architectural register file with rename (busy/tag) state, commit write-back
// and a registered operand bundle for each dispatch lane.
module renaming_register_file
  import ooo_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int XLEN     = XLEN_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int LANES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [LANES-1:0]         disp_valid,
  input  logic [LANES*5-1:0]       disp_rs1,
  input  logic [LANES*5-1:0]       disp_rs2,
  input  logic [LANES*5-1:0]       disp_rd,
  input  logic [LANES*TAG_W-1:0]   disp_tag,
  input  logic [LANES-1:0]         disp_wr,
  input  logic                     cm_valid,
  input  logic [4:0]               cm_rd,
  input  logic [TAG_W-1:0]         cm_tag,
  input  logic [XLEN-1:0]          cm_data,
  output logic [LANES-1:0]         op_valid,
  output logic [LANES*TAG_W-1:0]   op_tag,
  output logic [LANES-1:0]         op_rs1_rdy,
  output logic [LANES-1:0]         op_rs2_rdy,
  output logic [LANES*XLEN-1:0]    op_rs1_val,
  output logic [LANES*XLEN-1:0]    op_rs2_val
);

  rf_entry_t          rf_r [NUM_REGS];
  logic               ren_hit_s [NUM_REGS];
  logic [TAG_W-1:0]   ren_tag_s [NUM_REGS];

  logic               rs1_rdy_s [LANES];
  logic               rs2_rdy_s [LANES];
  logic [XLEN-1:0]    rs1_val_s [LANES];
  logic [XLEN-1:0]    rs2_val_s [LANES];

  logic [LANES-1:0]       op_valid_r;
  logic [LANES*TAG_W-1:0] op_tag_r;
  logic [LANES-1:0]       op_rs1_rdy_r;
  logic [LANES-1:0]       op_rs2_rdy_r;
  logic [LANES*XLEN-1:0]  op_rs1_val_r;
  logic [LANES*XLEN-1:0]  op_rs2_val_r;

  // Per-register rename request; the youngest lane naming rd wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      ren_hit_s[r] = 1'b0;
      ren_tag_s[r] = {TAG_W{1'b0}};
      for (int l = 0; l < LANES; l++) begin
        if ((r != 0) && disp_valid[l] && disp_wr[l] && (disp_rd[l*5 +: 5] == 5'(r))) begin
          ren_hit_s[r] = 1'b1;
          ren_tag_s[r] = disp_tag[l*TAG_W +: TAG_W];
        end else begin
          ren_hit_s[r] = ren_hit_s[r];
          ren_tag_s[r] = ren_tag_s[r];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rf_operand_lookup #(.LANES(LANES), .LANE(l)) u_rs1 (
      .src(disp_rs1[l*5 +: 5]), .entry(rf_r[disp_rs1[l*5 +: 5]]),
      .disp_valid(disp_valid), .disp_wr(disp_wr), .disp_rd(disp_rd), .disp_tag(disp_tag),
      .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_data(cm_data),
      .rdy(rs1_rdy_s[l]), .val(rs1_val_s[l])
    );
    rf_operand_lookup #(.LANES(LANES), .LANE(l)) u_rs2 (
      .src(disp_rs2[l*5 +: 5]), .entry(rf_r[disp_rs2[l*5 +: 5]]),
      .disp_valid(disp_valid), .disp_wr(disp_wr), .disp_rd(disp_rd), .disp_tag(disp_tag),
      .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_data(cm_data),
      .rdy(rs2_rdy_s[l]), .val(rs2_val_s[l])
    );
  end

  // Entry state: commit always writes the value; rename beats a same-cycle
  // commit on busy/tag, and a commit only retires the matching tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        rf_r[r].busy  <= 1'b0;
        rf_r[r].tag   <= {TAG_W{1'b0}};
        rf_r[r].value <= XLEN'(r);
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (cm_valid && (cm_rd == 5'(r))) begin
          rf_r[r].value <= cm_data;
        end else begin
          rf_r[r].value <= rf_r[r].value;
        end
        if (flush) begin
          rf_r[r].busy <= 1'b0;
        end else if (ren_hit_s[r]) begin
          rf_r[r].busy <= 1'b1;
          rf_r[r].tag  <= ren_tag_s[r];
        end else if (cm_valid && (cm_rd == 5'(r)) && (rf_r[r].tag == cm_tag)) begin
          rf_r[r].busy <= 1'b0;
        end else begin
          rf_r[r].busy <= rf_r[r].busy;
        end
      end
    end
  end

  // Operand bundle register; a flush kills the bundle being dispatched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_r   <= {LANES{1'b0}};
      op_tag_r     <= {(LANES*TAG_W){1'b0}};
      op_rs1_rdy_r <= {LANES{1'b0}};
      op_rs2_rdy_r <= {LANES{1'b0}};
      op_rs1_val_r <= {(LANES*XLEN){1'b0}};
      op_rs2_val_r <= {(LANES*XLEN){1'b0}};
    end else begin
      op_valid_r <= disp_valid & {LANES{~flush}};
      op_tag_r   <= disp_tag;
      for (int l = 0; l < LANES; l++) begin
        op_rs1_rdy_r[l]              <= rs1_rdy_s[l];
        op_rs2_rdy_r[l]              <= rs2_rdy_s[l];
        op_rs1_val_r[l*XLEN +: XLEN] <= rs1_val_s[l];
        op_rs2_val_r[l*XLEN +: XLEN] <= rs2_val_s[l];
      end
    end
  end

  assign op_valid   = op_valid_r;
  assign op_tag     = op_tag_r;
  assign op_rs1_rdy = op_rs1_rdy_r;
  assign op_rs2_rdy = op_rs2_rdy_r;
  assign op_rs1_val = op_rs1_val_r;
  assign op_rs2_val = op_rs2_val_r;

endmodule

// File: tb/tb_renaming_register_file.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural rename-table model.
module tb_renaming_register_file;

  localparam int LANES = 2;
  localparam int XLEN  = 32;
  localparam int TAG_W = 3;
  localparam int NR    = 32;

  logic                   clk = 1'b0;
  logic                   rst, flush;
  logic [LANES-1:0]       disp_valid, disp_wr;
  logic [LANES*5-1:0]     disp_rs1, disp_rs2, disp_rd;
  logic [LANES*TAG_W-1:0] disp_tag;
  logic                   cm_valid;
  logic [4:0]             cm_rd;
  logic [TAG_W-1:0]       cm_tag;
  logic [XLEN-1:0]        cm_data;
  logic [LANES-1:0]       op_valid, op_rs1_rdy, op_rs2_rdy;
  logic [LANES*TAG_W-1:0] op_tag;
  logic [LANES*XLEN-1:0]  op_rs1_val, op_rs2_val;

  int checks = 0;
  int failures = 0;

  bit              m_busy [NR];
  int unsigned     m_tag  [NR];
  logic [XLEN-1:0] m_val  [NR];

  renaming_register_file #(.NUM_REGS(NR), .XLEN(XLEN), .TAG_W(TAG_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd),
    .disp_tag(disp_tag), .disp_wr(disp_wr),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
    .op_valid(op_valid), .op_tag(op_tag), .op_rs1_rdy(op_rs1_rdy), .op_rs2_rdy(op_rs2_rdy),
    .op_rs1_val(op_rs1_val), .op_rs2_val(op_rs2_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_busy[r] = 1'b0;
      m_tag[r]  = 0;
      m_val[r]  = XLEN'(r);
    end
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = '0; disp_wr = '0;
    disp_rs1 = '0; disp_rs2 = '0; disp_rd = '0; disp_tag = '0;
    cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_data = '0;
  endtask

  task automatic disp(input int lane, input int rs1, input int rs2, input int rd,
                      input int tag, input bit wr);
    disp_valid[lane]          = 1'b1;
    disp_rs1[lane*5 +: 5]     = 5'(rs1);
    disp_rs2[lane*5 +: 5]     = 5'(rs2);
    disp_rd[lane*5 +: 5]      = 5'(rd);
    disp_tag[lane*TAG_W +: TAG_W] = TAG_W'(tag);
    disp_wr[lane]             = wr;
  endtask

  task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] data);
    cm_valid = 1'b1; cm_rd = 5'(rd); cm_tag = TAG_W'(tag); cm_data = data;
  endtask

  // Spec-level operand resolution for lane `lane` reading register `src`.
  function automatic void lookup(input int lane, input int src,
                                 output logic rdy, output logic [XLEN-1:0] v);
    int prod = -1;
    for (int i = 0; i < lane; i++)
      if (disp_valid[i] && disp_wr[i] && disp_rd[i*5 +: 5] == 5'(src)) prod = i;
    if (src == 0) begin rdy = 1'b1; v = '0; end
    else if (prod >= 0) begin rdy = 1'b0; v = XLEN'(disp_tag[prod*TAG_W +: TAG_W]); end
    else if (!m_busy[src]) begin rdy = 1'b1; v = m_val[src]; end
    else if (cm_valid && cm_tag == TAG_W'(m_tag[src])) begin rdy = 1'b1; v = cm_data; end
    else begin rdy = 1'b0; v = XLEN'(m_tag[src]); end
  endfunction

  // One clock: predict outputs and next state, clock, then compare.
  task automatic cycle(input string name);
    logic            e_r1 [LANES], e_r2 [LANES];
    logic [XLEN-1:0] e_v1 [LANES], e_v2 [LANES];
    logic [LANES-1:0] e_valid;
    logic [LANES*TAG_W-1:0] e_tag;
    bit              n_busy [NR];
    int unsigned     n_tag  [NR];
    logic [XLEN-1:0] n_val  [NR];
    int              ren    [NR];
    for (int l = 0; l < LANES; l++) begin
      lookup(l, int'(disp_rs1[l*5 +: 5]), e_r1[l], e_v1[l]);
      lookup(l, int'(disp_rs2[l*5 +: 5]), e_r2[l], e_v2[l]);
    end
    e_valid = flush ? '0 : disp_valid;
    e_tag   = disp_tag;
    for (int r = 0; r < NR; r++) begin
      n_busy[r] = m_busy[r]; n_tag[r] = m_tag[r]; n_val[r] = m_val[r]; ren[r] = -1;
    end
    if (cm_valid && cm_rd != 0) n_val[cm_rd] = cm_data;
    if (flush) begin
      for (int r = 0; r < NR; r++) n_busy[r] = 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (disp_valid[l] && disp_wr[l] && disp_rd[l*5 +: 5] != 0)
          ren[disp_rd[l*5 +: 5]] = int'(disp_tag[l*TAG_W +: TAG_W]);
      for (int r = 1; r < NR; r++) begin
        if (ren[r] >= 0) begin n_busy[r] = 1'b1; n_tag[r] = ren[r]; end
        else if (cm_valid && int'(cm_rd) == r && TAG_W'(m_tag[r]) == cm_tag) n_busy[r] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      m_busy[r] = n_busy[r]; m_tag[r] = n_tag[r]; m_val[r] = n_val[r];
    end
    check({name, "_valid"}, 64'(op_valid), 64'(e_valid));
    for (int l = 0; l < LANES; l++) begin
      if (e_valid[l]) begin
        check($sformatf("%s_l%0d_tag", name, l), 64'(op_tag[l*TAG_W +: TAG_W]), 64'(e_tag[l*TAG_W +: TAG_W]));
        check($sformatf("%s_l%0d_rdy1", name, l), 64'(op_rs1_rdy[l]), 64'(e_r1[l]));
        check($sformatf("%s_l%0d_val1", name, l), 64'(op_rs1_val[l*XLEN +: XLEN]), 64'(e_v1[l]));
        check($sformatf("%s_l%0d_rdy2", name, l), 64'(op_rs2_rdy[l]), 64'(e_r2[l]));
        check($sformatf("%s_l%0d_val2", name, l), 64'(op_rs2_val[l*XLEN +: XLEN]), 64'(e_v2[l]));
      end
    end
    idle();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, 64'(op_valid), 64'd0);
    check({name, "_tag"},   64'(op_tag), 64'd0);
    check({name, "_rdy"},   64'({op_rs1_rdy, op_rs2_rdy}), 64'd0);
    check({name, "_val1"},  64'(op_rs1_val), 64'd0);
    check({name, "_val2"},  64'(op_rs2_val), 64'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain lookup of reset values
    disp(0, 3, 4, 0, 0, 1'b0);
    cycle("r031");
    // Older lane's rename forwarded as a tag
    disp(0, 1, 2, 5, 2, 1'b1);
    disp(1, 5, 0, 0, 0, 1'b0);
    cycle("r032");
    // Commit bypass while reading the committing register
    commit(5, 2, 32'hAB);
    disp(0, 5, 0, 0, 0, 1'b0);
    cycle("r033a");
    disp(0, 5, 5, 0, 0, 1'b0);
    cycle("r033b");
    check("r033_rdy_const", 64'(op_rs1_rdy[0]), 64'd1);
    check("r033_val_const", 64'(op_rs1_val[31:0]), 64'hAB);
    // Stale commit must not retire a newer rename
    disp(0, 0, 0, 7, 1, 1'b1);
    cycle("r034a");
    disp(0, 0, 0, 7, 4, 1'b1);
    cycle("r034b");
    commit(7, 1, 32'd9);
    cycle("r034c");
    disp(0, 7, 0, 0, 0, 1'b0);
    cycle("r034d");
    check("r034_rdy_const", 64'(op_rs1_rdy[0]), 64'd0);
    check("r034_val_const", 64'(op_rs1_val[31:0]), 64'd4);
    // Both lanes rename r6: younger lane's tag survives
    disp(0, 0, 0, 6, 3, 1'b1);
    disp(1, 0, 0, 6, 5, 1'b1);
    cycle("r035a");
    commit(6, 3, 32'h66);
    cycle("r035b");
    disp(0, 6, 0, 0, 0, 1'b0);
    cycle("r035c");
    check("r035_val_const", 64'(op_rs1_val[31:0]), 64'd5);
    // Flush with a dispatch and commit in the same cycle
    flush = 1'b1;
    disp(0, 1, 2, 9, 6, 1'b1);
    disp(1, 3, 4, 10, 7, 1'b1);
    commit(12, 0, 32'h1234);
    cycle("r036a");
    disp(0, 6, 7, 0, 0, 1'b0);
    disp(1, 9, 12, 0, 0, 1'b0);
    cycle("r036b");
    check("r036_rdy_const", 64'({op_rs1_rdy, op_rs2_rdy}), 64'hF);
    check("r036_r12_const", 64'(op_rs2_val[63:32]), 64'h1234);
    // Writes to r0 are ignored
    disp(0, 0, 0, 0, 3, 1'b1);
    commit(0, 3, 32'hDEAD);
    disp(1, 0, 0, 0, 0, 1'b0);
    cycle("r0");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(3, 0) != 0)
          disp(l, $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0),
               $urandom_range(7, 0), 1'($urandom_range(1, 0)));
      end
      if ($urandom_range(1, 0) == 1)
        commit($urandom_range(15, 0), $urandom_range(7, 0), $urandom());
      flush = ($urandom_range(15, 0) == 0);
      cycle("rand");
    end

    // Reset asserted in the middle of an active bundle
    disp(0, 7, 5, 7, 2, 1'b1);
    disp(1, 7, 9, 9, 3, 1'b1);
    commit(5, 0, 32'hFFFF);
    flush = 1'b1;
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    @(posedge clk); #1;
    check_outputs_zero("midrst_edge");
    rst = 1'b0;
    model_reset();
    idle();
    disp(0, 7, 5, 0, 0, 1'b0);
    disp(1, 9, 31, 0, 0, 1'b0);
    cycle("postrst");
    check("postrst_r7_const", 64'(op_rs1_val[31:0]), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
